spad_echo_capture: RTL and testbench

SPAD_ECHO_CAPTURE -- requirements
Module: spad_echo_capture

---
 rtl/spad_echo_capture.sv | 198 +++++++++++++++++++
 tb/tb_spad_echo_capture.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spad_echo_capture.sv
// SPAD multi-echo capture: arms the detector on each frame start, timestamps
// up to MAX_ECHO synchronized hits within a RANGE_CYC window, and queues
// {tof, intensity, index} records in a 4-deep first-word-fall-through FIFO.
module spad_echo_capture #(
    parameter int MAX_ECHO  = 3,
    parameter int RANGE_CYC = 512,
    parameter int RST_CYC   = 2
) (
    input  logic        clk_250M,
    input  logic        rst_n,
    input  logic        TDC_start,
    input  logic        trig,
    input  logic [15:0] spad_int,
    output logic        rst_auto,
    output logic        busy,
    output logic        echo_valid,
    input  logic        echo_ready,
    output logic [8:0]  echo_tof,
    output logic [15:0] echo_int,
    output logic [1:0]  echo_idx,
    output logic        frame_done,
    output logic [1:0]  frame_cnt,
    output logic        overflow
);

    localparam int              RC_W     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [8:0]      CNT_LAST = 9'(RANGE_CYC - 1);
    localparam logic [1:0]      ECHO_MAX = 2'(MAX_ECHO);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_HIT,
        CLEAR,
        WAIT_LOW,
        DONE
    } state_t;

    state_t          state;
    logic [8:0]      cnt;
    logic [RC_W-1:0] rc;
    logic [1:0]      echo_cnt;
    logic [1:0]      echo_next;
    logic            start_d;
    logic            sync1, sync2, sync3;
    logic            start_edge, hit, timeout;

    logic [26:0]     mem [4];
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      fill;
    logic            push_req, push_ok, pop, full;
    logic [26:0]     head;

    assign start_edge = TDC_start & ~start_d;
    assign hit        = sync2 & ~sync3;
    assign timeout    = (cnt == CNT_LAST);
    assign echo_next  = echo_cnt + 2'd1;
    assign busy       = (state != IDLE);

    assign full       = (fill == 3'd4);
    assign echo_valid = (fill != 3'd0);
    assign pop        = echo_valid & echo_ready;
    assign push_req   = (state == WAIT_HIT) & hit;
    assign push_ok    = push_req & (~full | pop);
    assign head       = mem[rd_ptr];
    assign echo_tof   = echo_valid ? head[26:18] : 9'd0;
    assign echo_int   = echo_valid ? head[17:2]  : 16'd0;
    assign echo_idx   = echo_valid ? head[1:0]   : 2'd0;

    // Frame-start edge detector and trig synchronizer with a third stage for hit edge detection.
    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            start_d <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
        end else begin
            start_d <= TDC_start;
            sync1   <= trig;
            sync2   <= sync1;
            sync3   <= sync2;
        end
    end

    // Frame sequencer: arms/clears the detector, counts the window and flags frame completion.
    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 9'd0;
            rc         <= '0;
            echo_cnt   <= 2'd0;
            rst_auto   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            if ((state inside {ARM, WAIT_HIT, CLEAR, WAIT_LOW}) && !timeout) begin
                cnt <= cnt + 9'd1;
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= ARM;
                        cnt      <= 9'd0;
                        rc       <= '0;
                        echo_cnt <= 2'd0;
                        rst_auto <= 1'b1;
                    end
                end
                ARM: begin
                    if (rc == RC_LAST) begin
                        state    <= WAIT_HIT;
                        rst_auto <= 1'b0;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                WAIT_HIT: begin
                    if (hit) begin
                        echo_cnt <= echo_next;
                        if ((echo_next == ECHO_MAX) || timeout) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            frame_cnt  <= echo_next;
                        end else begin
                            state    <= CLEAR;
                            rst_auto <= 1'b1;
                            rc       <= '0;
                        end
                    end else if (timeout) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        frame_cnt  <= echo_cnt;
                    end
                end
                CLEAR: begin
                    if (timeout) begin
                        state      <= DONE;
                        rst_auto   <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= echo_cnt;
                    end else if (rc == RC_LAST) begin
                        state    <= WAIT_LOW;
                        rst_auto <= 1'b0;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (timeout) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        frame_cnt  <= echo_cnt;
                    end else if (!sync2) begin
                        state <= WAIT_HIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    rst_auto <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag (cleared by an accepted frame start).
    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fill     <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   fill <= fill + 3'd1;
                2'b01:   fill <= fill - 3'd1;
                default: fill <= fill;
            endcase
            if ((state == IDLE) && start_edge) begin
                overflow <= 1'b0;
            end else if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; stale words are never visible because the outputs are gated by echo_valid.
    always_ff @(posedge clk_250M) begin
        if (push_ok) mem[wr_ptr] <= {cnt, spad_int, echo_cnt};
    end

endmodule

// File: tb/tb_spad_echo_capture.sv
// Bench for spad_echo_capture: table-driven frames, randomized frames checked
// against a frame-level echo model, and hand-written overflow/reset sequences.
`timescale 1ns/1ps
module tb_spad_echo_capture;

    localparam int MAX_ECHO  = 3;
    localparam int RANGE_CYC = 512;
    localparam int RST_CYC   = 2;
    localparam int LOG_N     = RANGE_CYC + 16;

    logic        clk_250M = 1'b0;
    logic        rst_n;
    logic        TDC_start;
    logic        trig;
    logic [15:0] spad_int;
    logic        rst_auto;
    logic        busy;
    logic        echo_valid;
    logic        echo_ready;
    logic [8:0]  echo_tof;
    logic [15:0] echo_int;
    logic [1:0]  echo_idx;
    logic        frame_done;
    logic [1:0]  frame_cnt;
    logic        overflow;

    spad_echo_capture #(
        .MAX_ECHO (MAX_ECHO),
        .RANGE_CYC(RANGE_CYC),
        .RST_CYC  (RST_CYC)
    ) dut (
        .clk_250M  (clk_250M),
        .rst_n     (rst_n),
        .TDC_start (TDC_start),
        .trig      (trig),
        .spad_int  (spad_int),
        .rst_auto  (rst_auto),
        .busy      (busy),
        .echo_valid(echo_valid),
        .echo_ready(echo_ready),
        .echo_tof  (echo_tof),
        .echo_int  (echo_int),
        .echo_idx  (echo_idx),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt),
        .overflow  (overflow)
    );

    // 250 MHz clock
    always #2 clk_250M = ~clk_250M;

    typedef struct {
        int tof;
        int intens;
        int idx;
    } echo_t;

    typedef struct {
        int               n_hits;
        logic [3:0][9:0]  hit_cyc;
        int               hold_len;
        int               ready_mode;
        int               exp_cnt;
        int               exp_done;
        logic [2:0][9:0]  exp_tof;
    } frame_vec_t;

    echo_t pop_q[$];
    echo_t fifo_model[$];
    int    vec_count  = 0;
    int    miss_count = 0;
    int    cyc        = -1000;
    int    done_seen, done_cyc, done_cnt;
    bit    hold_trig  = 1'b0;
    bit    ovf_model;
    bit    rst_log  [LOG_N];
    bit    busy_log [LOG_N];

    task automatic checkOutput(input string name, input int actual, input int expected);
        vec_count++;
        if (actual != expected) begin
            miss_count++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    // One clock: record a pop, sample after the edge, emulate the detector clear.
    task automatic tick();
        echo_t e;
        if (echo_valid && echo_ready) begin
            e.tof    = int'(echo_tof);
            e.intens = int'(echo_int);
            e.idx    = int'(echo_idx);
            pop_q.push_back(e);
        end
        @(posedge clk_250M);
        #1;
        cyc++;
        if (frame_done) begin
            done_seen++;
            done_cyc = cyc;
            done_cnt = int'(frame_cnt);
        end
        if (rst_auto && !hold_trig) trig = 1'b0;
        if (cyc >= 0 && cyc < LOG_N) begin
            rst_log[cyc]  = rst_auto;
            busy_log[cyc] = busy;
        end
    endtask

    task automatic drainAndCompare();
        echo_ready = 1'b1;
        repeat (8) tick();
        checkOutput("echo_valid_after_drain", int'(echo_valid), 0);
        checkOutput("echo_count", pop_q.size(), fifo_model.size());
        for (int i = 0; i < pop_q.size() && i < fifo_model.size(); i++) begin
            checkOutput($sformatf("echo%0d_tof", i), pop_q[i].tof, fifo_model[i].tof);
            checkOutput($sformatf("echo%0d_int", i), pop_q[i].intens, fifo_model[i].intens);
            checkOutput($sformatf("echo%0d_idx", i), pop_q[i].idx, fifo_model[i].idx);
        end
        pop_q.delete();
        fifo_model.delete();
    endtask

    // Frame-level reference: every hit is seen two cycles after trig rises; the
    // first MAX_ECHO hits inside the window are kept, and a full frame ends one
    // cycle after its last capture, otherwise at the window end.
    function automatic frame_vec_t modelFrame(input frame_vec_t v);
        frame_vec_t r = v;
        r.exp_cnt = 0;
        r.exp_tof = '0;
        for (int k = 0; k < v.n_hits; k++) begin
            if (int'(v.hit_cyc[k]) + 2 <= RANGE_CYC - 1 && r.exp_cnt < MAX_ECHO) begin
                r.exp_tof[r.exp_cnt] = 10'(int'(v.hit_cyc[k]) + 2);
                r.exp_cnt++;
            end
        end
        r.exp_done = (r.exp_cnt == MAX_ECHO) ? int'(r.exp_tof[MAX_ECHO-1]) + 1 : RANGE_CYC;
        return r;
    endfunction

    function automatic frame_vec_t mk(input int n, input int h0, input int h1, input int h2,
                                      input int h3, input int hold, input int mode,
                                      input int cnt, input int done, input int t0,
                                      input int t1, input int t2);
        frame_vec_t v;
        v.n_hits     = n;
        v.hit_cyc[0] = 10'(h0);
        v.hit_cyc[1] = 10'(h1);
        v.hit_cyc[2] = 10'(h2);
        v.hit_cyc[3] = 10'(h3);
        v.hold_len   = hold;
        v.ready_mode = mode;
        v.exp_cnt    = cnt;
        v.exp_done   = done;
        v.exp_tof[0] = 10'(t0);
        v.exp_tof[1] = 10'(t1);
        v.exp_tof[2] = 10'(t2);
        return v;
    endfunction

    // Run one frame: start edge, trig pulses at the listed cycles, then check results.
    task automatic applyStimulus(input frame_vec_t v);
        int    ints [4];
        int    nmis_rst, nmis_busy, tof;
        bit    exp_rst;
        echo_t e;
        ovf_model  = 1'b0;
        done_seen  = 0;
        done_cyc   = -1;
        done_cnt   = -1;
        echo_ready = (v.ready_mode == 1);
        for (int k = 0; k < 4; k++) ints[k] = int'($urandom_range(0, 65535));
        TDC_start = 1'b1;
        cyc = -1;
        tick();
        TDC_start = 1'b0;
        hold_trig = (v.hold_len != 0);
        while (cyc < RANGE_CYC + 8) begin
            for (int k = 0; k < v.n_hits; k++) begin
                if (cyc == int'(v.hit_cyc[k])) begin
                    trig     = 1'b1;
                    spad_int = 16'(ints[k]);
                end
                if (v.hold_len != 0 && cyc == int'(v.hit_cyc[k]) + v.hold_len) trig = 1'b0;
            end
            if (v.ready_mode == 2) echo_ready = 1'($urandom_range(0, 1));
            tick();
        end
        hold_trig = 1'b0;

        for (int k = 0; k < v.exp_cnt; k++) begin
            e.tof    = int'(v.exp_tof[k]);
            e.intens = ints[k];
            e.idx    = k;
            if (v.ready_mode == 0 && fifo_model.size() >= 4) ovf_model = 1'b1;
            else fifo_model.push_back(e);
        end

        nmis_rst  = 0;
        nmis_busy = 0;
        for (int t = 0; t <= RANGE_CYC + 8; t++) begin
            exp_rst = (t < RST_CYC);
            for (int k = 0; k < v.exp_cnt; k++) begin
                tof = int'(v.exp_tof[k]);
                if (!(k == v.exp_cnt - 1 && v.exp_cnt == MAX_ECHO) &&
                    t > tof && t <= tof + RST_CYC && t <= RANGE_CYC - 1) exp_rst = 1'b1;
            end
            if (rst_log[t] != exp_rst) nmis_rst++;
            if (busy_log[t] != (t <= v.exp_done)) nmis_busy++;
        end

        checkOutput("frame_done_pulses", done_seen, 1);
        checkOutput("frame_done_cycle", done_cyc, v.exp_done);
        checkOutput("frame_cnt_at_done", done_cnt, v.exp_cnt);
        checkOutput("frame_cnt_held", int'(frame_cnt), v.exp_cnt);
        checkOutput("overflow", int'(overflow), int'(ovf_model));
        checkOutput("rst_auto_bad_cycles", nmis_rst, 0);
        checkOutput("busy_bad_cycles", nmis_busy, 0);
        if (v.ready_mode != 0) drainAndCompare();
    endtask

    frame_vec_t vecs [8];
    frame_vec_t rv;
    int         t_next, valid_seen;

    initial begin
        vecs[0] = mk(1, 40, 0, 0, 0,        0, 1, 1, 512, 42, 0, 0);
        vecs[1] = mk(4, 20, 100, 300, 400,  0, 1, 3, 303, 22, 102, 302);
        vecs[2] = mk(0, 0, 0, 0, 0,         0, 1, 0, 512, 0, 0, 0);
        vecs[3] = mk(1, 509, 0, 0, 0,       0, 2, 1, 512, 511, 0, 0);
        vecs[4] = mk(1, 510, 0, 0, 0,       0, 1, 0, 512, 0, 0, 0);
        vecs[5] = mk(2, 40, 100, 0, 0,     40, 1, 2, 512, 42, 102, 0);
        vecs[6] = mk(3, 20, 100, 300, 0,    0, 0, 3, 303, 22, 102, 302);
        vecs[7] = mk(3, 20, 100, 300, 0,    0, 0, 3, 303, 22, 102, 302);

        rst_n      = 1'b0;
        TDC_start  = 1'b0;
        trig       = 1'b0;
        spad_int   = 16'd0;
        echo_ready = 1'b0;
        repeat (3) @(posedge clk_250M);
        #1;
        checkOutput("reset_rst_auto", int'(rst_auto), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_echo_valid", int'(echo_valid), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        checkOutput("reset_frame_cnt", int'(frame_cnt), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            $display("[TB] table frame %0d", i);
            applyStimulus(vecs[i]);
        end
        drainAndCompare();

        for (int r = 0; r < 8; r++) begin
            rv            = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            rv.n_hits     = int'($urandom_range(0, 4));
            rv.ready_mode = int'($urandom_range(1, 2));
            t_next        = 5 + int'($urandom_range(0, 40));
            for (int k = 0; k < rv.n_hits; k++) begin
                rv.hit_cyc[k] = 10'(t_next);
                t_next += 20 + int'($urandom_range(0, 160));
            end
            rv = modelFrame(rv);
            $display("[TB] random frame %0d: %0d hits, %0d expected echoes", r, rv.n_hits, rv.exp_cnt);
            applyStimulus(rv);
        end

        // Reset while waiting for trig to fall with two echoes queued.
        echo_ready = 1'b0;
        done_seen  = 0;
        TDC_start  = 1'b1;
        cyc = -1;
        tick();
        TDC_start = 1'b0;
        hold_trig = 1'b1;
        while (cyc < 150) begin
            if (cyc == 20)  begin trig = 1'b1; spad_int = 16'h1111; end
            if (cyc == 60)  trig = 1'b0;
            if (cyc == 100) begin trig = 1'b1; spad_int = 16'h2222; end
            tick();
        end
        checkOutput("pre_reset_echo_valid", int'(echo_valid), 1);
        checkOutput("pre_reset_busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rst_auto", int'(rst_auto), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_echo_valid", int'(echo_valid), 0);
        checkOutput("midreset_echo_tof", int'(echo_tof), 0);
        checkOutput("midreset_echo_int", int'(echo_int), 0);
        checkOutput("midreset_echo_idx", int'(echo_idx), 0);
        checkOutput("midreset_frame_done", int'(frame_done), 0);
        checkOutput("midreset_frame_cnt", int'(frame_cnt), 0);
        checkOutput("midreset_overflow", int'(overflow), 0);
        trig      = 1'b0;
        hold_trig = 1'b0;
        repeat (3) @(posedge clk_250M);
        #1;
        rst_n      = 1'b1;
        done_seen  = 0;
        valid_seen = 0;
        repeat (600) begin
            tick();
            if (echo_valid) valid_seen++;
        end
        checkOutput("post_reset_frame_done", done_seen, 0);
        checkOutput("post_reset_valid_cycles", valid_seen, 0);
        checkOutput("post_reset_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
